// File: rtl/nebula_blk_pkg.sv
// Shared constants, slot index type and sequencer states for the instruction block unpacker.
// Slot 0 of a block occupies the most significant instruction word.
package nebula_blk_pkg;

    localparam int BLK_W   = 128;
    localparam int INSTR_W = 32;
    localparam int SLOTS   = 4;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [1:0] slot_idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } seq_state_t;

    function automatic logic [INSTR_W-1:0] slot_word(input logic [BLK_W-1:0] blk,
                                                     input slot_idx_t        idx);
        int base;
        base = (SLOTS - 1 - int'(idx)) * INSTR_W;
        return blk[base +: INSTR_W];
    endfunction

endpackage

// File: rtl/instr_block_unpacker_blk_fifo.sv
// blk_fifo: power-of-two entry FIFO with wrap-bit pointers and a synchronous flush.
// No bypass path: a push while full is dropped even when a pop happens in the same cycle.
module blk_fifo #(
    parameter int WIDTH = 135,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr_q[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries hold valid data.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/instr_block_unpacker.sv
// Unpacks 128-bit instruction blocks into a stream of 32-bit instructions with id/slot/last tags.
// Define INSTR_BLOCK_SKIP_NOP_EN to drop NOP slots at no cycle cost.
module instr_block_unpacker
    import nebula_blk_pkg::*;
#(
    parameter int ID_W  = 7,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               blk_valid_i,
    output logic               blk_ready_o,
    input  logic [BLK_W-1:0]   blk_data_i,
    input  logic [ID_W-1:0]    blk_id_i,
    input  logic               flush_i,
    output logic               ins_valid_o,
    input  logic               ins_ready_i,
    output logic [INSTR_W-1:0] ins_data_o,
    output logic [ID_W-1:0]    ins_id_o,
    output logic [1:0]         ins_slot_o,
    output logic               ins_last_o,
    output logic               busy_o
);

    localparam int ENTRY_W = BLK_W + ID_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic [ENTRY_W-1:0] head;
    logic [BLK_W-1:0]   head_blk;
    logic [ID_W-1:0]    head_id;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    logic               ready_en_q;
    seq_state_t         state_q, state_d;
    slot_idx_t          ptr_q, ptr_d;

    logic               push;
    logic               pop;
    logic               ins_fire;
    logic               cur_found;
    logic               cur_last;
    slot_idx_t          cur_slot;

    blk_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush_i),
        .push    (push),
        .wdata   ({blk_data_i, blk_id_i}),
        .pop     (pop),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign head_blk = head[ENTRY_W-1 -: BLK_W];
    assign head_id  = head[ID_W-1:0];

    // Ready is held low through reset and rises on the first edge after release.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) ready_en_q <= 1'b0;
        else         ready_en_q <= 1'b1;
    end

    assign blk_ready_o = ready_en_q && !fifo_full && !flush_i;
    assign push        = blk_valid_i && blk_ready_o;
    assign busy_o      = !fifo_empty;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cur_found = 1'b0;
        cur_slot  = ptr_q;
        cur_last  = 1'b1;
`ifdef INSTR_BLOCK_SKIP_NOP_EN
        // Scan high to low: the lowest live slot wins, and any earlier hit means it is not last.
        for (int s = SLOTS - 1; s >= 0; s--) begin
            if (slot_idx_t'(s) >= ptr_q && slot_word(head_blk, slot_idx_t'(s)) != NOP_INSTR) begin
                if (cur_found) cur_last = 1'b0;
                cur_found = 1'b1;
                cur_slot  = slot_idx_t'(s);
            end
        end
`else
        cur_found = 1'b1;
        cur_last  = (ptr_q == slot_idx_t'(SLOTS - 1));
`endif
    end

    assign ins_valid_o = (state_q == ISSUE) && cur_found;
    assign ins_fire    = ins_valid_o && ins_ready_i;
    // A head with nothing left to emit (all-NOP block) retires without a handshake.
    assign pop         = (state_q == ISSUE) && !flush_i &&
                         ((ins_fire && cur_last) || !cur_found);

    assign ins_data_o  = ins_valid_o ? slot_word(head_blk, cur_slot) : '0;
    assign ins_id_o    = ins_valid_o ? head_id : '0;
    assign ins_slot_o  = ins_valid_o ? cur_slot : '0;
    assign ins_last_o  = ins_valid_o && cur_last;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (flush_i) begin
            state_d = IDLE;
            ptr_d   = '0;
        end else begin
            if (pop) begin
                ptr_d = '0;
            end else if (ins_fire) begin
                ptr_d = cur_slot + slot_idx_t'(1);
            end
            case (state_q)
                IDLE:  if (push) state_d = ISSUE;
                ISSUE: if (pop && !push && fifo_count == CNT_W'(1)) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_instr_block_unpacker.sv
// Directed bench for instr_block_unpacker: latency, back-pressure, stalls, flush and reset.
// Note that reset_n is active-high here.
module tb_instr_block_unpacker;

    localparam int ID_W  = 7;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic            blk_valid_i = 1'b0;
    logic            blk_ready_o;
    logic [127:0]    blk_data_i = '0;
    logic [ID_W-1:0] blk_id_i = '0;
    logic            flush_i = 1'b0;
    logic            ins_valid_o;
    logic            ins_ready_i = 1'b0;
    logic [31:0]     ins_data_o;
    logic [ID_W-1:0] ins_id_o;
    logic [1:0]      ins_slot_o;
    logic            ins_last_o;
    logic            busy_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] t1w [4] = '{32'h0050_0513, 32'h0052_0293, 32'h0060_0593, 32'h0062_8313};

    always #5 clk = ~clk;

    instr_block_unpacker #(
        .ID_W  (ID_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .blk_valid_i (blk_valid_i),
        .blk_ready_o (blk_ready_o),
        .blk_data_i  (blk_data_i),
        .blk_id_i    (blk_id_i),
        .flush_i     (flush_i),
        .ins_valid_o (ins_valid_o),
        .ins_ready_i (ins_ready_i),
        .ins_data_o  (ins_data_o),
        .ins_id_o    (ins_id_o),
        .ins_slot_o  (ins_slot_o),
        .ins_last_o  (ins_last_o),
        .busy_o      (busy_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] word(input logic [31:0] base, input int k, input int s);
        return base + 32'(k * 16 + s);
    endfunction

    function automatic logic [127:0] mk_blk(input logic [31:0] base, input int k);
        return {word(base, k, 0), word(base, k, 1), word(base, k, 2), word(base, k, 3)};
    endfunction

    task automatic expect_ins(input string tag, input logic [31:0] d, input logic [ID_W-1:0] id,
                              input logic [1:0] s, input logic l);
        check(tag, {21'd0, ins_valid_o, ins_data_o, ins_id_o, ins_slot_o, ins_last_o},
                   {21'd0, 1'b1, d, id, s, l});
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {20'd0, blk_ready_o, ins_valid_o, ins_data_o, ins_id_o, ins_slot_o, ins_last_o, busy_o},
                   64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic pending;

        // Reset and release.
        repeat (2) @(posedge clk);
        #2;
        settle();
        check_all_zero("reset_outputs");
        reset_n = 1'b0;
        settle();
        check("ready_before_first_edge", blk_ready_o, 0);
        next_cycle();
        settle();
        check("ready_after_release", blk_ready_o, 1);

        // Single block, latency one, slots in order.
        ins_ready_i = 1'b1;
        blk_valid_i = 1'b1;
        blk_data_i  = {t1w[0], t1w[1], t1w[2], t1w[3]};
        blk_id_i    = 7'h01;
        settle();
        check("t1_accept", {ins_valid_o, blk_ready_o}, 2'b01);
        next_cycle();
        blk_valid_i = 1'b0;
        settle();
        for (int i = 0; i < 4; i++) begin
            expect_ins($sformatf("t1_slot%0d", i), t1w[i], 7'h01, 2'(i), i == 3);
            next_cycle();
            settle();
        end
        check("t1_drained", {ins_valid_o, busy_o}, 2'b00);

        // Three back-to-back blocks against a stalled decoder.
        ins_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            blk_valid_i = 1'b1;
            blk_data_i  = mk_blk(32'hA000_0000, k);
            blk_id_i    = 7'(7'h10 + k);
            settle();
            check($sformatf("t2_ready_blk%0d", k), blk_ready_o, 1);
            next_cycle();
        end
        blk_data_i = mk_blk(32'hA000_0000, 2);
        blk_id_i   = 7'h12;
        settle();
        check("t2_full_not_ready", {blk_ready_o, busy_o}, 2'b01);
        next_cycle();
        settle();
        check("t2_still_full", blk_ready_o, 0);
        ins_ready_i = 1'b1;
        pending     = 1'b1;
        for (n = 0; n < 12; n++) begin
            blk_valid_i = pending;
            settle();
            expect_ins($sformatf("t2_ins%0d", n), word(32'hA000_0000, n / 4, n % 4),
                       7'(7'h10 + n / 4), 2'(n % 4), (n % 4) == 3);
            if (n == 3) check("t2_no_bypass", blk_ready_o, 0);
            if (n == 4) check("t2_ready_after_pop", blk_ready_o, 1);
            if (blk_valid_i && blk_ready_o) pending = 1'b0;
            next_cycle();
        end
        check("t2_blk2_accepted", pending, 0);
        blk_valid_i = 1'b0;
        settle();
        check("t2_drained", {ins_valid_o, busy_o}, 2'b00);

        // Decoder ready toggling every cycle: outputs hold while stalled.
        ins_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            blk_valid_i = 1'b1;
            blk_data_i  = mk_blk(32'hC000_0000, k);
            blk_id_i    = 7'(7'h20 + k);
            next_cycle();
        end
        blk_valid_i = 1'b0;
        n = 0;
        for (int c = 0; c < 40 && n < 8; c++) begin
            ins_ready_i = c[0];
            settle();
            expect_ins($sformatf("t3_c%0d", c), word(32'hC000_0000, n / 4, n % 4),
                       7'(7'h20 + n / 4), 2'(n % 4), (n % 4) == 3);
            if (ins_valid_o && ins_ready_i) n++;
            next_cycle();
        end
        check("t3_count", 32'(n), 8);
        settle();
        check("t3_drained", {ins_valid_o, busy_o}, 2'b00);

        // Flush during slot 1 with a second block buffered and a push offered.
        ins_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            blk_valid_i = 1'b1;
            blk_data_i  = mk_blk(32'hE000_0000, k);
            blk_id_i    = 7'(7'h30 + k);
            next_cycle();
        end
        blk_valid_i = 1'b0;
        ins_ready_i = 1'b1;
        settle();
        expect_ins("t4_slot0", word(32'hE000_0000, 0, 0), 7'h30, 2'd0, 1'b0);
        next_cycle();
        flush_i     = 1'b1;
        blk_valid_i = 1'b1;
        blk_data_i  = mk_blk(32'hE000_0000, 2);
        blk_id_i    = 7'h32;
        settle();
        expect_ins("t4_slot1", word(32'hE000_0000, 0, 1), 7'h30, 2'd1, 1'b0);
        check("t4_flush_blocks_push", blk_ready_o, 0);
        next_cycle();
        flush_i     = 1'b0;
        blk_valid_i = 1'b0;
        settle();
        check("t4_after_flush", {ins_valid_o, busy_o}, 2'b00);
        repeat (3) next_cycle();
        settle();
        check("t4_push_dropped", {ins_valid_o, busy_o, blk_ready_o}, 3'b001);

`ifdef INSTR_BLOCK_SKIP_NOP_EN
        // NOP skipping: one live slot, then an all-NOP block.
        blk_valid_i = 1'b1;
        blk_data_i  = {32'h0000_0013, 32'h0041_8213, 32'h0000_0013, 32'h0000_0013};
        blk_id_i    = 7'h50;
        next_cycle();
        blk_valid_i = 1'b0;
        settle();
        expect_ins("t6_single", 32'h0041_8213, 7'h50, 2'd1, 1'b1);
        next_cycle();
        settle();
        check("t6_single_drained", {ins_valid_o, busy_o}, 2'b00);
        blk_valid_i = 1'b1;
        blk_data_i  = {4{32'h0000_0013}};
        blk_id_i    = 7'h51;
        next_cycle();
        blk_valid_i = 1'b0;
        settle();
        check("t6_allnop_silent", {ins_valid_o, busy_o}, 2'b01);
        next_cycle();
        settle();
        check("t6_allnop_popped", {ins_valid_o, busy_o}, 2'b00);
`endif

        // Reset asserted in the middle of a block.
        ins_ready_i = 1'b1;
        blk_valid_i = 1'b1;
        blk_data_i  = mk_blk(32'h5000_0000, 0);
        blk_id_i    = 7'h40;
        next_cycle();
        blk_valid_i = 1'b0;
        settle();
        expect_ins("t5_slot0", word(32'h5000_0000, 0, 0), 7'h40, 2'd0, 1'b0);
        next_cycle();
        settle();
        expect_ins("t5_slot1", word(32'h5000_0000, 0, 1), 7'h40, 2'd1, 1'b0);
        reset_n = 1'b1;
        #1;
        check_all_zero("t5_async_reset");
        next_cycle();
        reset_n = 1'b0;
        settle();
        check("t5_ready_held", blk_ready_o, 0);
        next_cycle();
        blk_valid_i = 1'b1;
        blk_data_i  = mk_blk(32'h6000_0000, 0);
        blk_id_i    = 7'h41;
        settle();
        check("t5_ready_again", {ins_valid_o, blk_ready_o}, 2'b01);
        next_cycle();
        blk_valid_i = 1'b0;
        settle();
        expect_ins("t5_new_slot0", word(32'h6000_0000, 0, 0), 7'h41, 2'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_block_unpacker.md
INSTR_BLOCK_UNPACKER -- requirements
Module: instr_block_unpacker

Interface
REQ-001 SHALL have parameter: ID_W, 7, block identifier width.
REQ-002 SHALL have parameter: DEPTH, 2, block buffer entries (power of two, >=2).
REQ-003 SHALL have port: clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port: reset_n  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: blk_valid_i  input  1  upstream block valid.
REQ-006 SHALL have port: blk_ready_o  output  1  block accepted when valid&ready.
REQ-007 SHALL have port: blk_data_i  input  128  four 32-bit instructions; slot 0 = [127:96], slot 3 = [31:0].
REQ-008 SHALL have port: blk_id_i  input  ID_W  block identifier.
REQ-009 SHALL have port: flush_i  input  1  discard all buffered blocks.
REQ-010 SHALL have port: ins_valid_o  output  1  instruction valid to decode.
REQ-011 SHALL have port: ins_ready_i  input  1  decode accepts on valid&ready.
REQ-012 SHALL have port: ins_data_o  output  32  instruction word.
REQ-013 SHALL have port: ins_id_o  output  ID_W  id of the owning block.
REQ-014 SHALL have port: ins_slot_o  output  2  slot index within block.
REQ-015 SHALL have port: ins_last_o  output  1  final emitted instruction of block.
REQ-016 SHALL have port: busy_o  output  1  buffer non-empty.

Function
REQ-017 SHALL buffer blocks in a DEPTH-entry FIFO with data, id; blk_ready_o = !full and !flush_i.
REQ-018 SHALL not bypass: when full, no push even if pop in same cycle; ready rises the cycle after pop.
REQ-019 SHALL present a block accepted in cycle N at the output in cycle N+1 when FIFO empty (latency 1).
REQ-020 SHALL have states IDLE (FIFO empty, ins_valid_o=0) and ISSUE (head present); IDLE->ISSUE on push, ISSUE->IDLE on last-slot pop with no other entry.
REQ-021 SHALL hold a slot pointer; emit head slot at pointer; advance pointer on ins handshake.
REQ-022 SHALL, on handshake of the last slot, pop the head and reset pointer to 0; next block issues the following cycle with no bubble.
REQ-023 SHALL hold ins_data_o/id/slot/last stable while ins_valid_o=1 and ins_ready_i=0.
REQ-024 SHALL handle simultaneous push and pop (not full): count unchanged, order preserved.
REQ-025 SHALL, on flush_i, empty FIFO and zero pointer at next edge; flush beats push and pop in same cycle; ins_valid_o=0 the cycle after.
REQ-026 SHALL wrap FIFO read/write pointers modulo DEPTH with an extra bit distinguishing full from empty.

Reset
REQ-027 SHALL, while reset_n=1, asynchronously clear FIFO, pointers, state=IDLE; outputs: blk_ready_o=0, ins_valid_o=0, ins_data_o=0, ins_id_o=0, ins_slot_o=0, ins_last_o=0, busy_o=0.
REQ-028 SHALL drive blk_ready_o=1 the first edge after reset release; reset mid-block discards it silently.

Configuration
REQ-029 SHALL, with INSTR_BLOCK_SKIP_NOP_EN defined, skip slots equal to 0x00000013 at zero cycle cost; ins_last_o marks last non-NOP slot; an all-NOP block pops in one cycle without emitting.
REQ-030 SHALL, without INSTR_BLOCK_SKIP_NOP_EN, emit all four slots, ins_last_o only on slot 3.

Structure
REQ-031 SHALL take BLK_W=128, INSTR_W=32, SLOTS=4, NOP_INSTR=32'h00000013, slot_idx_t from package nebula_blk_pkg.
REQ-032 SHALL implement buffering in sub-module blk_fifo (parameterised width, depth); slot sequencing in the top.

Verification
REQ-033 SHALL test: block {00500513,00520293,00600593,00628313}, id 01, ins_ready_i=1 -> 4 consecutive outputs slots 0..3 in that order, id 01, last on slot 3, first output 1 cycle after accept.
REQ-034 SHALL test: 3 back-to-back blocks, ins_ready_i=0 -> blk_ready_o falls after 2 accepts; then ready=1 -> 12 instructions in order, no bubbles.
REQ-035 SHALL test: ins_ready_i toggling every cycle -> outputs stable while stalled, no loss or duplication.
REQ-036 SHALL test: flush_i during slot 1 of block with second buffered, with simultaneous blk_valid_i -> ins_valid_o=0 next cycle, busy_o=0, pushed block dropped.
REQ-037 SHALL test (SKIP_NOP_EN): block {00000013,00418213,00000013,00000013} -> single output 00418213, slot 1, last=1; all-NOP block -> no output, popped in 1 cycle.
REQ-038 SHALL test: reset_n asserted mid-block -> all outputs 0 immediately; post-release first block issues from slot 0.
